traffic_phase_ctrl: RTL and testbench

Two-road (north-south / east-west) traffic-light phase controller clocked by the system clock and advanced by the one-cycle-per-second `tick` strobe from `counter_1hz`. It sequences green → yellow → all-red for each road, shortens a green on a latched pedestrian request, and falls back to flashing yellow when disabled. Its outputs drive the lamp drivers and the seconds-remaining display directly.

---
 rtl/traffic_pkg.sv | 40 ++++
 rtl/phase_timer.sv | 41 ++++
 rtl/traffic_phase_ctrl.sv | 138 +++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road phase controller: state codes, lamp codes.
// Also holds the fixed phase ring order and a green-state test used by the FSM.
// Pure declarations; no clocked logic.
package traffic_pkg;

  // Phase / state encoding, also driven out on the phase port
  localparam logic [2:0] NS_GREEN  = 3'd0;
  localparam logic [2:0] NS_YELLOW = 3'd1;
  localparam logic [2:0] CLR_A     = 3'd2;
  localparam logic [2:0] EW_GREEN  = 3'd3;
  localparam logic [2:0] EW_YELLOW = 3'd4;
  localparam logic [2:0] CLR_B     = 3'd5;
  localparam logic [2:0] FLASH     = 3'd6;

  // Lamp codes, bit order {red, yellow, green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  // Successor in the normal cycling ring; anything unexpected restarts at the clearance phase
  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    logic [2:0] nxt;
    case (ph)
      NS_GREEN:  nxt = NS_YELLOW;
      NS_YELLOW: nxt = CLR_A;
      CLR_A:     nxt = EW_GREEN;
      EW_GREEN:  nxt = EW_YELLOW;
      EW_YELLOW: nxt = CLR_B;
      CLR_B:     nxt = NS_GREEN;
      default:   nxt = CLR_B;
    endcase
    return nxt;
  endfunction

  function automatic logic is_green(input logic [2:0] ph);
    return (ph == NS_GREEN) || (ph == EW_GREEN);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Seconds-remaining down-counter for the current phase, with a last-second flag.
// Latency: load/decrement visible one clk after the request; last is decoded from the register.
// No backpressure: load takes priority over decrement, both are single-cycle requests.
module phase_timer #(
  parameter int CNT_W = 6,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: a load overrides a decrement in the same cycle
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register; reset lands on the clearance duration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road traffic phase controller: green/yellow/all-red per road, pedestrian shortening, flash fallback.
// Latency: tick or enable change is reflected on all outputs one clk later; outputs decode registers only.
// No backpressure: tick is consumed every cycle it is seen (a coincident disable swallows it).
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_SEC   = 25,
  parameter int YELLOW_SEC  = 3,
  parameter int ALL_RED_SEC = 2,
  parameter int PED_SEC     = 5,
  parameter int CNT_W       = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic             ped_req,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] remaining,
  output logic [2:0]       phase
);

  localparam logic [CNT_W-1:0] GREEN_V   = CNT_W'(GREEN_SEC);
  localparam logic [CNT_W-1:0] YELLOW_V  = CNT_W'(YELLOW_SEC);
  localparam logic [CNT_W-1:0] ALL_RED_V = CNT_W'(ALL_RED_SEC);
  localparam logic [CNT_W-1:0] PED_V     = CNT_W'(PED_SEC);

  logic [2:0]       state_q, state_d;
  logic             ped_pending_q, ped_pending_d;
  logic             flash_on_q, flash_on_d;
  logic             tmr_load, tmr_dec, tmr_last;
  logic [CNT_W-1:0] tmr_val;
  logic             entering_clr;

  // Duration loaded on entry to a phase
  function automatic logic [CNT_W-1:0] dur(input logic [2:0] ph);
    logic [CNT_W-1:0] d;
    case (ph)
      NS_GREEN, EW_GREEN:   d = GREEN_V;
      NS_YELLOW, EW_YELLOW: d = YELLOW_V;
      default:              d = ALL_RED_V;
    endcase
    return d;
  endfunction

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (ALL_RED_V)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .cnt      (remaining),
    .last     (tmr_last)
  );

  // State register plus the pedestrian latch and flash blinker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= CLR_B;
      ped_pending_q <= 1'b0;
      flash_on_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      flash_on_q    <= flash_on_d;
    end
  end

  // Next state and timer command; disable beats everything, including a same-cycle tick
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    if (!enable) begin
      state_d  = FLASH;
      tmr_load = 1'b1;
      tmr_val  = '0;
    end else if (state_q == FLASH) begin
      state_d  = CLR_B;
      tmr_load = 1'b1;
      tmr_val  = ALL_RED_V;
    end else if (tick) begin
      if (tmr_last) begin
        state_d  = next_phase(state_q);
        tmr_load = 1'b1;
        tmr_val  = dur(next_phase(state_q));
      end else if (is_green(state_q) && ped_pending_q && (remaining > PED_V)) begin
        tmr_load = 1'b1;
        tmr_val  = PED_V;
      end else begin
        tmr_dec = 1'b1;
      end
    end
  end

  // Pedestrian latch (set beats the clear on clearance entry) and flash toggle
  always_comb begin
    entering_clr = (state_d != state_q) && ((state_d == CLR_A) || (state_d == CLR_B));
    if (state_d == FLASH) begin
      ped_pending_d = 1'b0;
    end else begin
      ped_pending_d = ped_req | (ped_pending_q & ~entering_clr);
    end
    if (state_d != FLASH) begin
      flash_on_d = 1'b0;
    end else if ((state_q == FLASH) && tick) begin
      flash_on_d = ~flash_on_q;
    end else begin
      flash_on_d = flash_on_q;
    end
  end

  // Lamp decode from registered state only
  always_comb begin
    ns_light = OFF;
    ew_light = OFF;
    case (state_q)
      NS_GREEN:     begin ns_light = GRN; ew_light = RED; end
      NS_YELLOW:    begin ns_light = YEL; ew_light = RED; end
      EW_GREEN:     begin ns_light = RED; ew_light = GRN; end
      EW_YELLOW:    begin ns_light = RED; ew_light = YEL; end
      CLR_A, CLR_B: begin ns_light = RED; ew_light = RED; end
      FLASH: begin
        ns_light = flash_on_q ? YEL : OFF;
        ew_light = flash_on_q ? YEL : OFF;
      end
      default: begin ns_light = OFF; ew_light = OFF; end
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl with short durations and a tick every 4 clks.
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b1;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light, ew_light, phase;
  logic [5:0] remaining;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] ph;
    logic [5:0] rem;
    logic [2:0] ns;
    logic [2:0] ew;
  } exp_t;

  typedef struct {
    logic pr;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  traffic_phase_ctrl #(
    .GREEN_SEC(5), .YELLOW_SEC(2), .ALL_RED_SEC(1), .PED_SEC(2), .CNT_W(6)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .enable(enable), .ped_req(ped_req),
    .ns_light(ns_light), .ew_light(ew_light), .remaining(remaining), .phase(phase)
  );

  always #5 clk = ~clk;

  // Expected lamp pair for each non-flash phase
  function automatic exp_t mk(input logic [2:0] ph, input logic [5:0] rem);
    exp_t e;
    e.ph = ph;
    e.rem = rem;
    case (ph)
      NS_GREEN:  begin e.ns = 3'b001; e.ew = 3'b100; end
      NS_YELLOW: begin e.ns = 3'b010; e.ew = 3'b100; end
      EW_GREEN:  begin e.ns = 3'b100; e.ew = 3'b001; end
      EW_YELLOW: begin e.ns = 3'b100; e.ew = 3'b010; end
      default:   begin e.ns = 3'b100; e.ew = 3'b100; end
    endcase
    return e;
  endfunction

  function automatic exp_t mkf(input logic lit);
    exp_t e;
    e.ph = FLASH;
    e.rem = 6'd0;
    e.ns = lit ? 3'b010 : 3'b000;
    e.ew = lit ? 3'b010 : 3'b000;
    return e;
  endfunction

  function automatic vec_t v(input logic pr, input logic [2:0] ph, input logic [5:0] rem);
    vec_t r;
    r.pr = pr;
    r.e = mk(ph, rem);
    return r;
  endfunction

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (phase !== e.ph) begin errors++; $display("FAIL %s phase: got %0d want %0d", tag, phase, e.ph); end
    checks++;
    if (remaining !== e.rem) begin errors++; $display("FAIL %s remaining: got %0d want %0d", tag, remaining, e.rem); end
    checks++;
    if (ns_light !== e.ns) begin errors++; $display("FAIL %s ns_light: got %b want %b", tag, ns_light, e.ns); end
    checks++;
    if (ew_light !== e.ew) begin errors++; $display("FAIL %s ew_light: got %b want %b", tag, ew_light, e.ew); end
  endtask

  // One tick period: enable/ped in cycle 1, tick in cycle 4, outputs sampled just after that edge
  task automatic period(input logic en, input logic pr, input exp_t e, input string tag);
    @(negedge clk); enable = en; ped_req = pr; tick = 1'b0;
    @(negedge clk); ped_req = 1'b0;
    @(negedge clk);
    @(negedge clk); tick = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1; tick = 1'b0;
    check_pop(tag);
  endtask

  // A single clk with the given inputs
  task automatic step(input logic en, input logic pr, input logic tk, input exp_t e, input string tag);
    @(negedge clk); enable = en; ped_req = pr; tick = tk;
    sb.push_back(e);
    @(posedge clk); #1; tick = 1'b0; ped_req = 1'b0;
    check_pop(tag);
  endtask

  // Safety: never both roads green, and lamps always one-hot or dark
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ((ns_light[0] && ew_light[0]) || !$onehot0(ns_light) || !$onehot0(ew_light)) begin
        errors++;
        $display("FAIL lamp_safety: ns=%b ew=%b", ns_light, ew_light);
      end
    end
  end

  initial begin
    // Full cycle, pedestrian shortening, and no-shortening at the threshold
    tbl.push_back(v(0, NS_GREEN, 5));  tbl.push_back(v(0, NS_GREEN, 4));
    tbl.push_back(v(0, NS_GREEN, 3));  tbl.push_back(v(0, NS_GREEN, 2));
    tbl.push_back(v(0, NS_GREEN, 1));  tbl.push_back(v(0, NS_YELLOW, 2));
    tbl.push_back(v(0, NS_YELLOW, 1)); tbl.push_back(v(0, CLR_A, 1));
    tbl.push_back(v(0, EW_GREEN, 5));  tbl.push_back(v(0, EW_GREEN, 4));
    tbl.push_back(v(0, EW_GREEN, 3));  tbl.push_back(v(0, EW_GREEN, 2));
    tbl.push_back(v(0, EW_GREEN, 1));  tbl.push_back(v(0, EW_YELLOW, 2));
    tbl.push_back(v(0, EW_YELLOW, 1)); tbl.push_back(v(0, CLR_B, 1));
    tbl.push_back(v(0, NS_GREEN, 5));  tbl.push_back(v(0, NS_GREEN, 4));
    tbl.push_back(v(1, NS_GREEN, 2));  tbl.push_back(v(0, NS_GREEN, 1));
    tbl.push_back(v(0, NS_YELLOW, 2)); tbl.push_back(v(0, NS_YELLOW, 1));
    tbl.push_back(v(0, CLR_A, 1));     tbl.push_back(v(1, EW_GREEN, 5));
    tbl.push_back(v(0, EW_GREEN, 2));  tbl.push_back(v(0, EW_GREEN, 1));
    tbl.push_back(v(0, EW_YELLOW, 2)); tbl.push_back(v(0, EW_YELLOW, 1));
    tbl.push_back(v(0, CLR_B, 1));     tbl.push_back(v(0, NS_GREEN, 5));
    tbl.push_back(v(0, NS_GREEN, 4));  tbl.push_back(v(0, NS_GREEN, 3));
    tbl.push_back(v(0, NS_GREEN, 2));  tbl.push_back(v(0, NS_GREEN, 1));
    tbl.push_back(v(0, NS_YELLOW, 2)); tbl.push_back(v(0, NS_YELLOW, 1));
    tbl.push_back(v(0, CLR_A, 1));     tbl.push_back(v(0, EW_GREEN, 5));
    tbl.push_back(v(0, EW_GREEN, 4));  tbl.push_back(v(0, EW_GREEN, 3));
    tbl.push_back(v(0, EW_GREEN, 2));  tbl.push_back(v(1, EW_GREEN, 1));
    tbl.push_back(v(0, EW_YELLOW, 2)); tbl.push_back(v(0, EW_YELLOW, 1));
    tbl.push_back(v(0, CLR_B, 1));     tbl.push_back(v(0, NS_GREEN, 5));
    tbl.push_back(v(0, NS_GREEN, 4));  tbl.push_back(v(0, NS_GREEN, 3));
    tbl.push_back(v(0, NS_GREEN, 2));  tbl.push_back(v(0, NS_GREEN, 1));
    tbl.push_back(v(0, NS_YELLOW, 2)); tbl.push_back(v(0, NS_YELLOW, 1));
    tbl.push_back(v(0, CLR_A, 1));     tbl.push_back(v(0, EW_GREEN, 5));
    tbl.push_back(v(0, EW_GREEN, 4));

    // Reset state while reset is held
    repeat (3) @(negedge clk);
    sb.push_back(mk(CLR_B, 1));
    check_pop("reset");
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      period(1'b1, tbl[i].pr, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Disable mid EW_GREEN: flash dark first, then blinks per tick, ped ignored
    step(1'b0, 1'b0, 1'b0, mkf(1'b0), "flash_entry");
    period(1'b0, 1'b1, mkf(1'b1), "flash_tick1");
    period(1'b0, 1'b0, mkf(1'b0), "flash_tick2");
    period(1'b0, 1'b0, mkf(1'b1), "flash_tick3");
    step(1'b1, 1'b0, 1'b0, mk(CLR_B, 1), "flash_exit");
    period(1'b1, 1'b0, mk(NS_GREEN, 5), "after_flash_g5");
    period(1'b1, 1'b0, mk(NS_GREEN, 4), "after_flash_g4");

    // Asynchronous reset mid NS_YELLOW
    period(1'b1, 1'b0, mk(NS_GREEN, 3), "pre_rst_g3");
    period(1'b1, 1'b0, mk(NS_GREEN, 2), "pre_rst_g2");
    period(1'b1, 1'b0, mk(NS_GREEN, 1), "pre_rst_g1");
    period(1'b1, 1'b0, mk(NS_YELLOW, 2), "pre_rst_y2");
    #3 rst = 1'b1;
    #1;
    sb.push_back(mk(CLR_B, 1));
    check_pop("async_rst");
    @(negedge clk); rst = 1'b0;
    period(1'b1, 1'b0, mk(NS_GREEN, 5), "post_rst_g5");

    // Disable coincident with the CLR_A expiry tick: EW_GREEN never shows
    period(1'b1, 1'b0, mk(NS_GREEN, 4), "c_g4");
    period(1'b1, 1'b0, mk(NS_GREEN, 3), "c_g3");
    period(1'b1, 1'b0, mk(NS_GREEN, 2), "c_g2");
    period(1'b1, 1'b0, mk(NS_GREEN, 1), "c_g1");
    period(1'b1, 1'b0, mk(NS_YELLOW, 2), "c_y2");
    period(1'b1, 1'b0, mk(NS_YELLOW, 1), "c_y1");
    period(1'b1, 1'b0, mk(CLR_A, 1), "c_clra");
    @(negedge clk); @(negedge clk); @(negedge clk);
    step(1'b0, 1'b0, 1'b1, mkf(1'b0), "disable_on_tick");
    step(1'b0, 1'b0, 1'b0, mkf(1'b0), "flash_hold");
    period(1'b0, 1'b0, mkf(1'b1), "flash_after_tick");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
